// File: rtl/fft_mag.sv
// Streams FFT bins through an alpha-max-plus-beta-min magnitude pipeline into the spectrum register.
// Define FFT_MAG_BITREV_EN to read the FFT result register in bit-reversed address order.
module fft_mag #(
    parameter int NPOINT  = 128,
    parameter int FFT_AW  = 8,
    parameter int SPEC_AW = 7,
    parameter int DW      = 40,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [FFT_AW-1:0]  fft_addr,
    output logic               fft_rd_en,
    input  logic [DW-1:0]      fft_datar,
    input  logic [DW-1:0]      fft_datai,
    output logic [SPEC_AW-1:0] spec_addr,
    output logic [DW:0]        spec_data,
    output logic               spec_wren,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(NPOINT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_map;

    // Valid bit and bin index travel alongside the FFT read latency
    logic [RD_LAT-1:0]         rv_q;
    logic [RD_LAT-1:0][CW-1:0] ridx_q;

    logic            a_vld_q;
    logic [CW-1:0]   a_idx_q;
    logic [DW-1:0]   a_absr_q, a_absi_q;

    logic            b_vld_q;
    logic [CW-1:0]   b_idx_q;
    logic [DW-1:0]   b_mx_q, b_mn_q;

    logic            pipe_last;
    logic [DW:0]     mx_w, mn_w;

`ifdef FFT_MAG_BITREV_EN
    for (genvar gi = 0; gi < CW; gi++) begin : g_rev
        assign cnt_map[gi] = cnt_q[CW-1-gi];
    end
`else
    assign cnt_map = cnt_q;
`endif

    // Two's complement magnitude; the most negative value maps to 2^(DW-1) as unsigned
    function automatic logic [DW-1:0] abs_u(input logic [DW-1:0] x);
        return x[DW-1] ? (~x + DW'(1)) : x;
    endfunction

    assign pipe_last = b_vld_q && !a_vld_q && !(|rv_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fft_rd_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                fft_rd_en = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(NPOINT - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fft_addr = fft_rd_en ? FFT_AW'(cnt_map) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv_q   <= '0;
            ridx_q <= '0;
        end else begin
            rv_q[0]   <= fft_rd_en;
            ridx_q[0] <= cnt_q;
            for (int k = 1; k < RD_LAT; k++) begin
                rv_q[k]   <= rv_q[k-1];
                ridx_q[k] <= ridx_q[k-1];
            end
        end
    end

    // Stage A captures |I|,|Q| on the data-valid cycle; stage B orders them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_vld_q  <= 1'b0;
            a_idx_q  <= '0;
            a_absr_q <= '0;
            a_absi_q <= '0;
            b_vld_q  <= 1'b0;
            b_idx_q  <= '0;
            b_mx_q   <= '0;
            b_mn_q   <= '0;
        end else begin
            a_vld_q <= rv_q[RD_LAT-1];
            if (rv_q[RD_LAT-1]) begin
                a_idx_q  <= ridx_q[RD_LAT-1];
                a_absr_q <= abs_u(fft_datar);
                a_absi_q <= abs_u(fft_datai);
            end
            b_vld_q <= a_vld_q;
            if (a_vld_q) begin
                b_idx_q <= a_idx_q;
                if (a_absr_q >= a_absi_q) begin
                    b_mx_q <= a_absr_q;
                    b_mn_q <= a_absi_q;
                end else begin
                    b_mx_q <= a_absi_q;
                    b_mn_q <= a_absr_q;
                end
            end
        end
    end

    assign mx_w      = {1'b0, b_mx_q};
    assign mn_w      = {1'b0, b_mn_q};
    assign spec_data = mx_w + (mn_w >> 2) + (mn_w >> 3);
    assign spec_wren = b_vld_q;
    assign spec_addr = SPEC_AW'(b_idx_q);

endmodule

// File: tb/tb_fft_mag.sv
// Scoreboard bench for fft_mag: driver pushes expected reads/writes/done/busy, a monitor pops and compares.
// Honours FFT_MAG_BITREV_EN when choosing the expected FFT read order.
module tb_fft_mag;
    localparam int NPOINT  = 128;
    localparam int FFT_AW  = 8;
    localparam int SPEC_AW = 7;
    localparam int DW      = 40;
    localparam int LOGN    = 7;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [FFT_AW-1:0]  fft_addr;
    logic               fft_rd_en;
    logic [DW-1:0]      fft_datar, fft_datai;
    logic [SPEC_AW-1:0] spec_addr;
    logic [DW:0]        spec_data;
    logic               spec_wren, busy, done;

    fft_mag dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fft_addr  (fft_addr),
        .fft_rd_en (fft_rd_en),
        .fft_datar (fft_datar),
        .fft_datai (fft_datai),
        .spec_addr (spec_addr),
        .spec_data (spec_data),
        .spec_wren (spec_wren),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem_r [256];
    logic signed [DW-1:0] mem_i [256];

    // FFT result register with one cycle read latency
    always @(posedge clk) begin
        fft_datar <= mem_r[fft_addr];
        fft_datai <= mem_i[fft_addr];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          cyc;
        int          addr;
        logic [63:0] val;
    } exp_t;

    exp_t wq[$];
    exp_t aq[$];
    exp_t bq[$];
    int   dq[$];

    int          n_checks = 0;
    int          n_errors = 0;
    bit          end_req = 1'b0;
    logic [63:0] last_data = '0;

    function automatic int addr_map(input int k);
        int r;
        r = k;
`ifdef FFT_MAG_BITREV_EN
        r = 0;
        for (int b = 0; b < LOGN; b++)
            if (((k >> b) & 1) != 0) r += (1 << (LOGN - 1 - b));
`endif
        return r;
    endfunction

    function automatic logic [63:0] ref_mag(input longint re, input longint im);
        longint ar, ai, mx, mn;
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        mx = (ar > ai) ? ar : ai;
        mn = (ar > ai) ? ai : ar;
        return 64'(mx + mn / 4 + mn / 8);
    endfunction

    function automatic logic signed [DW-1:0] rnd_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: return {1'b1, {(DW-1){1'b0}}};
            1: return {1'b0, {(DW-1){1'b1}}};
            2: return '0;
            3: return DW'(longint'($urandom_range(0, 2000)) - 1000);
            default: return w[DW-1:0];
        endcase
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", nm, act, req, edge_cnt);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 256; a++) begin
            mem_r[a] = rnd_word();
            mem_i[a] = rnd_word();
            if ($urandom_range(0, 9) == 0) mem_i[a] = -mem_r[a];
        end
    endtask

    // Cycle k of a frame (k=1 is the first cycle after the accepting edge) has edge_cnt == e+k-1
    task automatic run_frame(input int repulse_cyc, input int abort_cyc);
        int   e;
        exp_t x;
        e = edge_cnt + 1;
        for (int k = 0; k < NPOINT; k++) begin
            x.cyc  = e + 3 + k;
            x.addr = k;
            x.val  = ref_mag(mem_r[addr_map(k)], mem_i[addr_map(k)]);
            wq.push_back(x);
            x.cyc  = e + k;
            x.addr = addr_map(k);
            x.val  = '0;
            aq.push_back(x);
        end
        dq.push_back(e + NPOINT + 3);
        x.cyc  = e;
        x.addr = e + NPOINT + 3;
        x.val  = '0;
        bq.push_back(x);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < e + NPOINT + 8) begin
            start = (edge_cnt == e + repulse_cyc - 1);
            if (edge_cnt == e + abort_cyc - 1) reset = 1'b1;
            if (edge_cnt == e + abort_cyc + 1) reset = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Driver
    initial begin
        for (int a = 0; a < 256; a++) begin
            mem_r[a] = '0;
            mem_i[a] = '0;
        end
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        for (int a = 0; a < 256; a++) begin
            mem_r[a] = -40'sd800;
            mem_i[a] = 40'sd400;
        end
        run_frame(-10, -10);

        fill_random();
        mem_r[addr_map(5)] = {1'b1, {(DW-1){1'b0}}};
        mem_i[addr_map(5)] = '0;
        mem_r[addr_map(6)] = 40'sd3;
        mem_i[addr_map(6)] = -40'sd4;
        mem_r[addr_map(7)] = '0;
        mem_i[addr_map(7)] = '0;
        run_frame(50, -10);

        fill_random();
        run_frame(-10, 60);

        fill_random();
        run_frame(-10, -10);

        repeat (5) @(negedge clk);
        end_req = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t x;
        bit   busy_exp;
        forever begin
            @(negedge clk);
            #1;
            if (edge_cnt > 20000) begin
                chk(1'b0, "timeout", 64'(edge_cnt), 64'd20000);
                $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                $finish;
            end
            if (end_req) begin
                chk(wq.size() == 0, "missing_writes", 64'(wq.size()), 64'd0);
                chk(aq.size() == 0, "missing_reads", 64'(aq.size()), 64'd0);
                chk(dq.size() == 0, "missing_done", 64'(dq.size()), 64'd0);
                $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                $finish;
            end
            if (reset) begin
                wq.delete();
                aq.delete();
                dq.delete();
                bq.delete();
                last_data = '0;
                chk(fft_addr == '0, "rst_fft_addr", 64'(fft_addr), 64'd0);
                chk(fft_rd_en == 1'b0, "rst_fft_rd_en", 64'(fft_rd_en), 64'd0);
                chk(spec_addr == '0, "rst_spec_addr", 64'(spec_addr), 64'd0);
                chk(spec_data == '0, "rst_spec_data", 64'(spec_data), 64'd0);
                chk(spec_wren == 1'b0, "rst_spec_wren", 64'(spec_wren), 64'd0);
                chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
                chk(done == 1'b0, "rst_done", 64'(done), 64'd0);
            end else begin
                if (aq.size() > 0 && aq[0].cyc == edge_cnt) begin
                    x = aq.pop_front();
                    chk(fft_rd_en == 1'b1, "rd_en", 64'(fft_rd_en), 64'd1);
                    chk(fft_addr == FFT_AW'(x.addr), "fft_addr", 64'(fft_addr), 64'(x.addr));
                end else if (fft_rd_en) begin
                    chk(1'b0, "unexpected_read", 64'(fft_addr), 64'd0);
                end

                if (spec_wren) begin
                    if (wq.size() == 0) begin
                        chk(1'b0, "unexpected_write", 64'(spec_addr), 64'd0);
                    end else begin
                        x = wq.pop_front();
                        chk(edge_cnt == x.cyc, "write_cycle", 64'(edge_cnt), 64'(x.cyc));
                        chk(spec_addr == SPEC_AW'(x.addr), "spec_addr", 64'(spec_addr), 64'(x.addr));
                        chk(64'(spec_data) == x.val, "spec_data", 64'(spec_data), x.val);
                    end
                    last_data = 64'(spec_data);
                end else begin
                    if (wq.size() > 0 && wq[0].cyc <= edge_cnt) begin
                        x = wq.pop_front();
                        chk(1'b0, "write_missing", 64'(spec_wren), 64'd1);
                    end
                    chk(64'(spec_data) == last_data, "spec_hold", 64'(spec_data), last_data);
                end

                if (done) begin
                    if (dq.size() == 0) chk(1'b0, "unexpected_done", 64'(done), 64'd0);
                    else chk(dq.pop_front() == edge_cnt, "done_cycle", 64'(edge_cnt), 64'(edge_cnt));
                end else if (dq.size() > 0 && dq[0] <= edge_cnt) begin
                    void'(dq.pop_front());
                    chk(1'b0, "done_missing", 64'(done), 64'd1);
                end

                busy_exp = (bq.size() > 0) && (edge_cnt >= bq[0].cyc) && (edge_cnt <= bq[0].addr);
                chk(busy == busy_exp, "busy", 64'(busy), 64'(busy_exp));
                if (bq.size() > 0 && edge_cnt >= bq[0].addr) void'(bq.pop_front());
            end
        end
    end
endmodule

// File: doc/fft_mag.md
Name: fft_mag

Overview:
- Downstream neighbour of the FFT stage in the MFCC front end.
- After the FFT signals completion, this block walks the FFT result register. For each bin it reads the real and imaginary words and computes an approximate magnitude |I+jQ| using alpha-max-plus-beta-min.
- Each 41-bit magnitude is written into the spectrum (energy) register, which feeds the mel filterbank adder.
- Pipelined: one bin issued per clock.

Parameters:
- NPOINT, 128, number of bins processed (power of two, 2..256).
- FFT_AW, 8, FFT result register address width.
- SPEC_AW, 7, spectrum register address width; must satisfy 2^SPEC_AW >= NPOINT.
- DW, 40, signed width of FFT real/imag words.
- RD_LAT, 1, FFT register read latency in cycles (1..2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, driven by the FFT completion pulse.
- fft_addr  out  FFT_AW  read address into the FFT result register.
- fft_rd_en  out  1  read strobe, high while an address is being issued.
- fft_datar  in  DW  real part, two's complement; valid RD_LAT cycles after the address.
- fft_datai  in  DW  imaginary part, two's complement; valid RD_LAT cycles after the address.
- spec_addr  out  SPEC_AW  spectrum register write address.
- spec_data  out  DW+1  magnitude, unsigned.
- spec_wren  out  1  spectrum register write enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - FSM goes to IDLE.
  - All counters, pipeline registers and valid bits clear.
  - Every output goes to 0: fft_addr, fft_rd_en, spec_addr, spec_data, spec_wren, busy, done.
  - A partially processed frame is abandoned; nothing further is written.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN; the read counter clears to 0.
  - RUN: fft_rd_en=1 and fft_addr = read counter (zero-extended); the counter increments each cycle. At counter = NPOINT-1 -> DRAIN.
  - DRAIN: fft_rd_en=0; wait until the pipeline empties (last write issued) -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored and causes no restart.
- busy=1 in RUN, DRAIN and DONE.
- Pipeline: a valid bit and the bin index are carried alongside the data, delayed RD_LAT cycles from address issue.
  - Stage A (registered on the data-valid cycle): |I| and |Q| as DW-bit unsigned values.
  - The most negative input -2^(DW-1) maps to 2^(DW-1) with no saturation.
  - Stage B (registered): mx = max(|I|,|Q|), mn = min(|I|,|Q|).
  - spec_data = mx + (mn>>2) + (mn>>3), computed in DW+1 bits with truncating shifts.
  - spec_wren=1 and spec_addr = bin index, in natural order.
- Latency: the address issued in cycle c is written in cycle c+RD_LAT+2.
- Cycle budget, with start accepted at edge 0 and RD_LAT=1:
  - Addresses are issued in cycles 1..NPOINT.
  - Writes occur in cycles 4..NPOINT+3.
  - done pulses in cycle NPOINT+4.
- Throughput: one write per cycle with no gaps.
- spec_wren is never asserted outside the write window.
- spec_data holds its last value when spec_wren=0.
- Equal magnitudes (|I|=|Q|): mx=|I|, mn=|Q|; the result is identical either way.
- Zero input gives 0.

Optional Feature:
- Macro FFT_MAG_BITREV_EN.
- Defined: fft_addr presents the read counter bit-reversed over log2(NPOINT) bits, with the upper bits zero. This reads in-place FFT output that is stored in bit-reversed order. spec_addr stays in natural order.
- Not defined: fft_addr equals the natural-order counter.
- Latency and timing are identical in both builds.

Test Plan:
- Reset then idle -> all outputs 0. A start pulse while reset=1 -> no activity.
- Frame of NPOINT=128, all bins r=-800, i=400, start at cycle 0 -> 128 writes in cycles 4..131, each spec_data=950 (800+100+50), spec_addr 0..127 consecutive. done=1 only in cycle 132; busy=1 in cycles 1..132.
- Bin 5 r=-2^39, i=0 -> spec_data[5]=549755813888. Bin 6 r=3, i=-4 -> 4. Bin 7 r=0, i=0 -> 0.
- start re-pulsed at cycle 50 mid-frame -> ignored; still exactly 128 writes and one done.
- reset asserted at cycle 60, released at cycle 62 -> outputs 0 immediately, no further writes. A new start then runs a full frame from address 0.
- FFT_MAG_BITREV_EN defined, NPOINT=128 -> fft_addr sequence 0,64,32,96,16,...; spec_addr still 0,1,2,... with the data from the bit-reversed location.
